uart_rx: RTL
============

# uart_rx

Receive side of the team's UART link. It oversamples a serial line (idle high, LSB first) at PRESCALE clocks per bit and detects the start bit. It reassembles 8 data bits, optionally checks an even/odd parity bit, checks the stop bit, and presents the byte with a one-cycle valid strobe. Frame format and parity convention match the transmitter: start(0), D0..D7, optional parity, stop(1).

## Interface
- PRESCALE, default 8: clocks per serial bit; even, >= 4.
- i_clk  input  1  system clock; all logic is on the rising edge.
- i_rst  input  1  asynchronous, active-low reset.
- i_serial_data  input  1  asynchronous serial line; idle = 1.
- i_parity_enable  input  1  1 = a parity bit follows D7; sampled at start-bit detection and held for the frame.
- i_parity_type  input  1  0 = even, 1 = odd; sampled with i_parity_enable.
- o_p_data  output  8  last received byte; D0 = bit 0.
- o_data_valid  output  1  one-cycle strobe; o_p_data is a good frame (parity OK if enabled, stop = 1).
- o_parity_error  output  1  one-cycle strobe; parity mismatch on the completed frame.
- o_stop_error  output  1  one-cycle strobe; stop bit sampled as 0.
- o_busy  output  1  high while the FSM is not IDLE.

## Operation
- Input synchronizer: 2 flops, reset to 1. The FSM uses only the synchronized bit `rx_s`.
- Bit counter `cnt`, width clog2(PRESCALE). It is cleared on entry to START. It increments every cycle outside IDLE and wraps PRESCALE-1 -> 0. A wrap ends the current bit.
- Sample point: `cnt == PRESCALE/2 - 1`. There is one sample per bit and no majority vote.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx_s == 0, go to START, clear cnt, and latch the parity controls.
  - START: at the sample point, rx_s == 1 is a glitch; go to IDLE with no strobes. At the wrap with a valid start, go to DATA with bit index 0.
  - DATA: at the sample point, shift rx_s into the data shift register, LSB first. After the wrap of bit 7, go to PARITY if enabled, else to STOP.
  - PARITY: at the sample point, store rx_s. At the wrap, go to STOP.
  - STOP: at the sample point, evaluate the frame (next bullet) and go directly to IDLE. The second half of the stop bit is not waited out, so a back-to-back start edge is caught.
- Frame evaluation at the STOP sample point, registered on the next edge:
  - o_p_data <= shift register. It updates on every completed frame, including errored ones.
  - Parity: compute `perr = ^data ^ pbit ^ i_parity_type`. The check passes when perr = 0, meaning the XOR of data bits and parity bit is 0 for even and 1 for odd. perr is forced to 0 when parity is disabled.
  - Stop: compute `serr = ~rx_s`.
  - Output: o_data_valid = ~perr & ~serr; o_parity_error = perr; o_stop_error = serr.
- The parity controls are frozen for the frame. Changes mid-frame take effect on the next frame.
- Line behaviour: a line held low forever restarts a frame immediately after the stop-error frame. Each frame then reports a stop error.

## Timing
- Reset (async, i_rst = 0) values: FSM = IDLE, cnt = 0, synchronizer = 1, o_p_data = 8'h00, all strobes = 0, o_busy = 0.
- Reset asserted mid-frame aborts the frame with no strobes. After release, the block waits for a new falling edge.
- Edge detect: a line falling edge reaches IDLE detection 2 clocks later. o_busy rises on the edge after detection.
- Sampling: each bit is sampled PRESCALE/2 cycles after its nominal start, delayed by the synchronizer.
- Strobe latency:
  - Strobes fire 1 clock after the STOP sample point.
  - From the line falling edge, that is about 2 + (9 + P)·PRESCALE + PRESCALE/2 + 1 clocks, with P = parity enable.
  - Strobes are high for exactly one cycle.
- o_busy falls in the same cycle the strobes rise.
- o_p_data holds its value until the next completed frame.

## Test plan
- PRESCALE = 8, parity off, send 0xA5 -> one o_data_valid pulse, o_p_data = 8'hA5, no errors, o_busy low afterwards.
- Parity even enabled, send 0xA5 with pbit 0 -> valid, data A5. Repeat with pbit 1 -> o_parity_error pulse, o_data_valid = 0, o_p_data = A5. Odd type, 0x01 with pbit 0 -> valid.
- Send 0x3C with a stop bit of 0 -> o_stop_error pulse, no valid. A following good 0x55 frame -> valid, data 55.
- Line low for 2 clocks then high (glitch) -> o_busy pulses for fewer than PRESCALE cycles, no strobes, and the next real frame 0x0F is received correctly.
- Two frames 0x12, 0x34 back-to-back with no idle gap -> two valid pulses, with data 12 then 34.
- Reset asserted at bit D3 of a frame -> all outputs return to reset values immediately, no strobe. The next frame 0xFF is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, PRESCALE oversampling, 8 data bits LSB first,
// optional even/odd parity, stop check, one-cycle result strobes.
module uart_rx #(
  parameter int unsigned PRESCALE = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_serial_data,
  input  logic       i_parity_enable,
  input  logic       i_parity_type,
  output logic [7:0] o_p_data,
  output logic       o_data_valid,
  output logic       o_parity_error,
  output logic       o_stop_error,
  output logic       o_busy
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(PRESCALE / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             pbit_q;
  logic             par_en_q;
  logic             par_type_q;

  logic rx_s;
  logic wrap_c;
  logic sample_c;
  logic perr_c;
  logic serr_c;

  assign rx_s     = sync_q[1];
  assign wrap_c   = (cnt_q == CNT_MAX);
  assign sample_c = (cnt_q == CNT_SAMPLE);
  assign perr_c   = par_en_q & (^shift_q ^ pbit_q ^ par_type_q);
  assign serr_c   = ~rx_s;

  // Line synchronizer; resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_serial_data};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      pbit_q         <= 1'b0;
      par_en_q       <= 1'b0;
      par_type_q     <= 1'b0;
      o_p_data       <= '0;
      o_data_valid   <= 1'b0;
      o_parity_error <= 1'b0;
      o_stop_error   <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_data_valid   <= 1'b0;
      o_parity_error <= 1'b0;
      o_stop_error   <= 1'b0;
      cnt_q          <= wrap_c ? '0 : cnt_q + CNT_W'(1);

      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q    <= S_START;
            o_busy     <= 1'b1;
            par_en_q   <= i_parity_enable;
            par_type_q <= i_parity_type;
          end
        end

        S_START: begin
          if (sample_c && rx_s) begin
            state_q <= S_IDLE;
            o_busy  <= 1'b0;
          end else if (wrap_c) begin
            state_q   <= S_DATA;
            bit_idx_q <= '0;
          end
        end

        S_DATA: begin
          if (sample_c) begin
            shift_q <= {rx_s, shift_q[7:1]};
          end
          if (wrap_c) begin
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= par_en_q ? S_PARITY : S_STOP;
            end
          end
        end

        S_PARITY: begin
          if (sample_c) begin
            pbit_q <= rx_s;
          end
          if (wrap_c) begin
            state_q <= S_STOP;
          end
        end

        // Leave at mid-stop so a back-to-back start edge is not missed.
        S_STOP: begin
          if (sample_c) begin
            state_q        <= S_IDLE;
            o_busy         <= 1'b0;
            o_p_data       <= shift_q;
            o_data_valid   <= ~perr_c & ~serr_c;
            o_parity_error <= perr_c;
            o_stop_error   <= serr_c;
          end
        end

        default: begin
          state_q <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
